// File: rtl/psum_adder_arbiter.sv
// Round-robin scheduler sharing one external W-bit adder among NREQ requesters,
// with a single-entry tagged result register. Optional saturation: ADDER_ARB_SAT_EN.
module psum_adder_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 24,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W-1:0]      add_s,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [IDW-1:0]    res_id,
    output logic [15:0]       ops_cnt
);

    logic [IDW-1:0] r_ptr;
    logic           r_res_valid;
    logic [W-1:0]   r_res_sum;
    logic           r_res_cout;
    logic [IDW-1:0] r_res_id;
    logic [15:0]    r_ops_cnt;

    logic [IDW-1:0] w_cand_idx [NREQ];
    logic [NREQ-1:0] w_cand_vld;
    logic           w_any;
    logic [IDW-1:0] w_grant_idx;
    logic           w_slot_free;
    logic           w_fire;
    logic           w_pop;
    logic [IDW-1:0] w_sel;
    logic [31:0]    w_inc;
    logic [IDW-1:0] w_ptr_next;
    logic [W-1:0]   w_sum_next;

    // Candidate gi is the requester at distance gi above the pointer, modulo NREQ.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            logic [31:0] w_raw;
            assign w_raw          = 32'(r_ptr) + 32'(gi);
            assign w_cand_idx[gi] = (w_raw >= 32'(NREQ)) ? IDW'(w_raw - 32'(NREQ)) : IDW'(w_raw);
            assign w_cand_vld[gi] = req_valid[w_cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_any       = 1'b0;
        w_grant_idx = r_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_cand_vld[k]) begin
                w_any       = 1'b1;
                w_grant_idx = w_cand_idx[k];
            end
        end
    end

    assign w_slot_free = !r_res_valid || res_ready;
    assign w_fire      = w_any && w_slot_free && !rst;
    assign w_pop       = r_res_valid && res_ready;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = w_fire && (w_grant_idx == IDW'(gi));
        end
    endgenerate

    // With no grant the adder still sees a defined operand pair (the pointer's).
    assign w_sel = w_fire ? w_grant_idx : r_ptr;
    assign add_a = req_a[w_sel*W +: W];
    assign add_b = req_b[w_sel*W +: W];

    assign w_inc      = 32'(w_grant_idx) + 32'd1;
    assign w_ptr_next = (w_inc >= 32'(NREQ)) ? '0 : IDW'(w_inc);

`ifdef ADDER_ARB_SAT_EN
    assign w_sum_next = add_cout ? {W{1'b1}} : add_s;
`else
    assign w_sum_next = add_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_id    <= '0;
            r_ops_cnt   <= '0;
        end else begin
            if (w_fire) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= w_sum_next;
                r_res_cout  <= add_cout;
                r_res_id    <= w_grant_idx;
                r_ptr       <= w_ptr_next;
            end else if (w_pop) begin
                r_res_valid <= 1'b0;
            end
            if (w_pop) begin
                r_ops_cnt <= r_ops_cnt + 16'd1;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign res_id    = r_res_id;
    assign ops_cnt   = r_ops_cnt;

endmodule

// File: tb/tb_psum_adder_arbiter.sv
// Directed bench for psum_adder_arbiter; models the shared adder combinationally.
// Honours ADDER_ARB_SAT_EN for the overflow expectation.
module tb_psum_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 24;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_s;
    logic              add_cout;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [IDW-1:0]    res_id;
    logic [15:0]       ops_cnt;

    int n_cmp;
    int n_fail;
    int exp_cnt;

    psum_adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .ops_cnt   (ops_cnt)
    );

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        exp_cnt   = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 24'h000100 * (i + 1), 24'(i + 1));

        // Reset with every requester valid
        tick();
        check("rst1_ready", 32'(req_ready), 32'h0);
        check("rst1_valid", 32'(res_valid), 32'h0);
        check("rst1_cnt",   32'(ops_cnt),   32'h0);
        tick();
        check("rst2_ready", 32'(req_ready), 32'h0);
        check("rst2_sum",   32'(res_sum),   32'h0);
        check("rst2_id",    32'(res_id),    32'h0);
        check("rst2_cout",  32'(res_cout),  32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_grant", 32'(req_ready), 32'h1);
        req_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(req_ready), 32'h0);
        tick();
        check("idle_valid", 32'(res_valid), 32'h0);

        // Single op from requester 2
        set_ops(2, 24'h000010, 24'h000005);
        req_valid = 4'b0100;
        #1;
        check("single_ready", 32'(req_ready), 32'h4);
        check("single_adda",  32'(add_a),     32'h10);
        tick();
        req_valid = 4'b0000;
        check("single_valid", 32'(res_valid), 32'h1);
        check("single_sum",   32'(res_sum),   32'h000015);
        check("single_cout",  32'(res_cout),  32'h0);
        check("single_id",    32'(res_id),    32'h2);
        tick();
        check("single_popped", 32'(res_valid), 32'h0);
        check("single_cnt",    32'(ops_cnt),   32'h1);

        // Round robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(2, 24'h000300, 24'h000003);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("rr%0d_id", k),  32'(res_id),  32'(k % 4));
            check($sformatf("rr%0d_sum", k), 32'(res_sum), 32'(24'h000101 * ((k % 4) + 1)));
            check($sformatf("rr%0d_vld", k), 32'(res_valid), 32'h1);
        end
        req_valid = 4'b0000;
        tick();
        check("rr_cnt",   32'(ops_cnt),   32'd6);
        check("rr_valid", 32'(res_valid), 32'h0);

        // Backpressure: requester 1 then 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("bp_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1000;
        #1;
        check("bp_blocked", 32'(req_ready), 32'h0);
        check("bp_id1",     32'(res_id),    32'h1);
        tick();
        tick();
        check("bp_hold_valid", 32'(res_valid), 32'h1);
        check("bp_hold_sum",   32'(res_sum),   32'h000202);
        check("bp_hold_id",    32'(res_id),    32'h1);
        check("bp_hold_ready", 32'(req_ready), 32'h0);
        res_ready = 1'b1;
        #1;
        check("bp_grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        check("bp_valid3", 32'(res_valid), 32'h1);
        check("bp_id3",    32'(res_id),    32'h3);
        check("bp_sum3",   32'(res_sum),   32'h000404);
        check("bp_cnt1",   32'(ops_cnt),   32'h1);
        tick();
        check("bp_cnt2", 32'(ops_cnt), 32'h2);

        // Carry / overflow on requester 0
        set_ops(0, 24'hFFFFFF, 24'h000002);
        req_valid = 4'b0001;
        #1;
        check("ovf_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
`ifdef ADDER_ARB_SAT_EN
        check("ovf_sum", 32'(res_sum), 32'hFFFFFF);
`else
        check("ovf_sum", 32'(res_sum), 32'h000001);
`endif
        check("ovf_cout", 32'(res_cout), 32'h1);
        tick();

        // Counter wrap after 65536 pops
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(0, 24'h000001, 24'h000001);
        req_valid = 4'b0001;
        for (int n = 0; n < 65536; n++) tick();
        req_valid = 4'b0000;
        check("wrap_ffff", 32'(ops_cnt), 32'hFFFF);
        tick();
        check("wrap_zero", 32'(ops_cnt), 32'h0000);

        // Reset while a result is pending
        res_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        check("mid_valid_pre", 32'(res_valid), 32'h1);
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        check("mid_ready_rst", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        check("mid_valid", 32'(res_valid), 32'h0);
        check("mid_sum",   32'(res_sum),   32'h0);
        check("mid_id",    32'(res_id),    32'h0);
        #1;
        check("mid_ptr0", 32'(req_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_adder_arbiter.md
# psum_adder_arbiter

Round-robin scheduler that time-shares one 24-bit carry-lookahead adder among several partial-sum requesters in the convolution accumulation path. Each requester presents an operand pair with a valid/ready handshake. The arbiter drives the shared adder's operand inputs combinationally, captures sum and carry into a single-entry output register, and tags the result with the requester index. It sits between the MAC lanes and the accumulator write-back stage.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal range 2–8.
- W, 24, operand width; must match the instantiated adder.
- IDW, 2, width of the requester index; must satisfy 2^IDW ≥ NREQ.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B; same packing as req_a.
- add_a  out  W  to shared adder input A.
- add_b  out  W  to shared adder input B.
- add_s  in  W  sum from shared adder (combinational).
- add_cout  in  1  carry-out from shared adder.
- res_valid  out  1  result register holds data.
- res_ready  in  1  downstream accepts result.
- res_sum  out  W  registered sum.
- res_cout  out  1  registered carry-out.
- res_id  out  IDW  index of the requester that produced the result.
- ops_cnt  out  16  count of results consumed downstream; wraps.

## Operation
- slot_free = !res_valid || res_ready.
- Arbitration is combinational:
  - When slot_free, grant the first requester with req_valid set, searching from pointer ptr upward modulo NREQ.
  - req_ready[g] = 1 for the granted index g only.
  - No grant when slot_free = 0 or when no req_valid is set.
- add_a and add_b:
  - Carry req_a/req_b of g while a grant exists.
  - Otherwise carry the operands of index ptr. This value is don't-care, but it must be deterministic.
- Transfer fires on req_valid[g] && req_ready[g]. At the next edge:
  - res_sum ← add_s, res_cout ← add_cout, res_id ← g, res_valid ← 1.
  - ptr ← (g+1) mod NREQ.
- Downstream pop (res_valid && res_ready) with no new transfer: res_valid ← 0. res_sum, res_cout and res_id hold their values.
- A pop and a transfer in the same cycle are legal. The register reloads, res_valid stays 1, and throughput is one operation per cycle.
- ops_cnt increments on every pop and wraps from 0xFFFF to 0.
- ptr changes only on a transfer; it never advances on idle cycles.
- Requesters must hold req_valid and operands stable until granted. The arbiter never drops a granted operation.
- Arithmetic is unsigned modulo 2^W. The carry is reported in res_cout.

## Timing
- Grant latency: 0 cycles (same cycle as valid, when the slot is free).
- Result latency: 1 cycle from transfer to res_valid.
- Back-to-back throughput: 1 op/clk while res_ready = 1.
- Fairness: a continuously asserting requester is granted within NREQ transfers.
- Reset (rst = 1 at an edge), including mid-operation:
  - res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, ops_cnt = 0, ptr = 0.
  - A transfer in the reset cycle is discarded.
  - req_ready is forced to 0 while rst = 1.
- res_* outputs are stable while res_valid && !res_ready (backpressure hold).

## Configuration
- ADDER_ARB_SAT_EN defined: on a transfer with add_cout = 1, res_sum is loaded with all ones (2^W−1) and res_cout is still loaded as 1. Unsigned saturation is intended for activation accumulation.
- ADDER_ARB_SAT_EN undefined: res_sum ← add_s unconditionally, giving wrap-around.
- All other behaviour is identical in both builds.

## Test plan
- Reset values: assert rst for 2 cycles with all req_valid set. Required: req_ready = 0, res_valid = 0, ops_cnt = 0. After release, first grant goes to requester 0.
- Single op: requester 2 sends A = 0x000010, B = 0x000005 with res_ready = 1.
  - req_ready = 0b0100 in the same cycle.
  - Next cycle: res_valid = 1, res_sum = 0x000015, res_cout = 0, res_id = 2.
  - ops_cnt = 1 after the pop.
- Round-robin fairness: all 4 requesters valid continuously, res_ready = 1. Required grant order 0,1,2,3,0,1, one grant per cycle.
- Backpressure:
  - Hold res_ready = 0 with requesters 1 and 3 valid. One transfer from requester 1 occurs, then req_ready = 0 while res_* stays stable.
  - Raise res_ready. The pop and the requester-3 transfer happen in the same cycle, and res_valid stays 1.
- Carry/overflow: A = 0xFFFFFF, B = 0x000002.
  - ADDER_ARB_SAT_EN undefined: res_sum = 0x000001, res_cout = 1.
  - ADDER_ARB_SAT_EN defined: res_sum = 0xFFFFFF, res_cout = 1.
- Counter wrap and mid-op reset:
  - Preload by streaming 65536 pops. Required: ops_cnt = 0x0000.
  - Assert rst while res_valid = 1. Required: res_valid = 0 and ptr = 0 on the next cycle.
